pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer that replaces the fixed 32-bit PC register at the head of the fetch stage. It holds the current fetch address and selects the next one from these sources:

- reset vector
- exception vector
- branch/jump redirect, with a pending-redirect latch for stalled cycles
- a small return-address stack (RAS) for call/return prediction
- sequential increment

A RUN/HALTED state machine lets the control unit park fetch without losing a redirect.

## Interface
- WIDTH, 32: address width in bits (≥ 8).
- RESET_VECTOR, 0: PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180: PC value loaded on Exception (truncated to WIDTH).
- INC, 4: sequential increment; power of two.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥ 2.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  hold PC this cycle (hazard unit).
- Redirect  in  1  branch/jump resolved taken.
- RedirectTarget  in  WIDTH  target for Redirect.
- Exception  in  1  trap request.
- Call  in  1  fetched instruction is a call; push PC+INC.
- Return  in  1  fetched instruction is a return; pop RAS as next PC.
- Halt  in  1  enter HALTED.
- Resume  in  1  leave HALTED.
- PCResult  out  WIDTH  current fetch address (registered).
- PCValid  out  1  1 in RUN, 0 in HALTED.
- RasEmpty  out  1  RAS holds no entries.
- RasUnderflow  out  1  one-cycle pulse: Return taken with RAS empty.

## Operation
- States: RUN, HALTED. Reset places the block in RUN.
- Reset values:
  - PCResult = RESET_VECTOR
  - PCValid = 1
  - RAS count = 0, so RasEmpty = 1
  - RasUnderflow = 0
  - pending-redirect flag clear
- Next-PC priority in RUN, highest first:
  - Reset → RESET_VECTOR.
  - Exception → EXC_VECTOR. Overrides Stall. Clears the pending redirect. The RAS is untouched.
  - Stall → PC holds. If Redirect is asserted, RedirectTarget is latched as pending; a later Redirect overwrites it. Call and Return are ignored.
  - Redirect → RedirectTarget.
  - Pending redirect → latched target; the flag clears.
  - Return → RAS top; pop. If the RAS is empty: PC+INC, pulse RasUnderflow, count stays 0.
  - Otherwise → PC+INC, modulo 2^WIDTH (wraps silently).
- Call, when not stalled and not overridden by Exception or Reset, pushes PCResult+INC.
- When Call and Return fall in the same unstalled cycle, the pop happens first and then the push. Net effect: the top entry is replaced and the count is unchanged.
- Call, Return and the pending redirect act only in the cycle the PC actually advances through the Redirect/Return/sequential path.
- RAS push when full (count = RAS_DEPTH) overwrites the oldest entry (circular buffer). Count saturates at RAS_DEPTH.
- Halt in RUN, with no Exception: go to HALTED and hold PC. Halt wins over Redirect/sequential. A Redirect in that cycle is latched as pending.
- In HALTED:
  - PC holds and PCValid = 0.
  - Redirect is latched as pending.
  - Call and Return are ignored.
  - Resume → RUN; PC still holds that cycle.
  - Exception → RUN with PC = EXC_VECTOR; pending redirect cleared.
- Halt and Resume asserted together in HALTED: Resume wins. In RUN: Halt wins.

## Timing
- PCResult and PCValid are registered: a decision in cycle N is visible after edge N+1.
- Redirect latency is 1 cycle. A pending redirect is applied on the first cycle with Stall = 0 in RUN, following Resume.
- RasEmpty reflects the count after the edge. RasUnderflow is high for exactly the one cycle after the offending edge.
- Reset asserted mid-stall, mid-halt or with pending state fully restores reset values at the next edge.

## Test plan
- Reset then 3 free cycles, WIDTH=32 → PCResult 0, 4, 8, 12; PCValid = 1; RasEmpty = 1.
- PC=0x10, Stall=1 with Redirect to 0x200, then Stall held 2 more cycles, then released → PC stays 0x10 for 3 cycles, then 0x200.
- PC=0x40, Call; PC=0x100, Call; then Return, Return, Return:
  - first two Returns → next PCs 0x104, then 0x44
  - third Return → RasUnderflow pulse, PC advances by INC
- RAS_DEPTH=4, 5 Calls at PCs 0x0, 0x10, 0x20, 0x30, 0x40, then 4 Returns → targets 0x44, 0x34, 0x24, 0x14; RasEmpty = 1 afterwards.
- Stall=1, Redirect pending and Exception asserted together → PC = 0x180 next cycle; after Stall drops the PC advances to 0x184, not the redirect target.
- PC=0xFFFFFFFC, WIDTH=32, one free cycle → PC wraps to 0x0.
- Halt at PC=0x20, Redirect to 0x300 while HALTED, Resume → PCValid = 0 while halted; PC holds 0x20 through the Resume cycle, then 0x300 with PCValid = 1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with exception/redirect/RAS/sequential
// next-PC selection, a pending-redirect latch for stalled or halted cycles,
// and a RUN/HALTED state machine so the control unit can park fetch.
module pc_sequencer #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter logic [31:0]        EXC_VECTOR   = 32'h0000_0180,
  parameter int                 INC          = 4,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] RedirectTarget,
  input  logic             Exception,
  input  logic             Call,
  input  logic             Return,
  input  logic             Halt,
  input  logic             Resume,
  output logic [WIDTH-1:0] PCResult,
  output logic             PCValid,
  output logic             RasEmpty,
  output logic             RasUnderflow
);

  localparam int               PTR_W  = $clog2(RAS_DEPTH);
  localparam int               CNT_W  = $clog2(RAS_DEPTH) + 1;
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(RAS_DEPTH);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [WIDTH-1:0] pend_target_reg, pend_target_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             underflow_reg, underflow_next;

  // Return-address stack as a circular buffer: ptr points at the next write
  // slot, so when full the slot being overwritten is the oldest entry.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic [WIDTH-1:0] ras_wdata;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_top;
  logic             advance;

  assign pc_inc  = pc_reg + INC_W;
  assign ras_top = ras_mem[ptr_reg - PTR_W'(1)];

  // Next-state, next-PC and RAS update selection in priority order.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    ptr_next         = ptr_reg;
    count_next       = count_reg;
    underflow_next   = 1'b0;
    ras_we           = 1'b0;
    ras_waddr        = ptr_reg;
    ras_wdata        = pc_inc;
    advance          = 1'b0;

    if (Exception) begin
      // Trap overrides stall and halt; RAS is left alone.
      state_next      = ST_RUN;
      pc_next         = EXC_PC;
      pend_valid_next = 1'b0;
    end else if (state_reg == ST_HALTED) begin
      if (Redirect) begin
        pend_valid_next  = 1'b1;
        pend_target_next = RedirectTarget;
      end
      // PC still holds in the Resume cycle; Resume beats a concurrent Halt.
      if (Resume) begin
        state_next = ST_RUN;
      end
    end else if (Halt || Stall) begin
      // Fetch is parked; keep the most recent redirect for later.
      if (Redirect) begin
        pend_valid_next  = 1'b1;
        pend_target_next = RedirectTarget;
      end
      if (Halt) begin
        state_next = ST_HALTED;
      end
    end else begin
      advance         = 1'b1;
      pend_valid_next = 1'b0;
      if (Redirect) begin
        pc_next = RedirectTarget;
      end else if (pend_valid_reg) begin
        pc_next = pend_target_reg;
      end else if (Return && (count_reg != '0)) begin
        pc_next = ras_top;
      end else begin
        pc_next = pc_inc;
      end
    end

    // RAS acts only on advancing cycles: pop first, then push, so a
    // simultaneous call/return replaces the top entry.
    if (advance) begin
      if (Return) begin
        if (count_reg == '0) begin
          underflow_next = 1'b1;
        end else begin
          ptr_next   = ptr_reg - PTR_W'(1);
          count_next = count_reg - CNT_W'(1);
        end
      end
      if (Call) begin
        ras_we    = 1'b1;
        ras_waddr = ptr_next;
        ras_wdata = pc_inc;
        ptr_next  = ptr_next + PTR_W'(1);
        if (count_next != FULL) begin
          count_next = count_next + CNT_W'(1);
        end
      end
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= ST_RUN;
      pc_reg          <= RESET_VECTOR;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
      ptr_reg         <= '0;
      count_reg       <= '0;
      underflow_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      ptr_reg         <= ptr_next;
      count_reg       <= count_next;
      underflow_reg   <= underflow_next;
    end
  end

  // RAS storage write port; contents need no reset since count gates reads.
  always_ff @(posedge Clk) begin
    if (ras_we && !Reset) begin
      ras_mem[ras_waddr] <= ras_wdata;
    end
  end

  assign PCResult     = pc_reg;
  assign PCValid      = (state_reg == ST_RUN);
  assign RasEmpty     = (count_reg == '0);
  assign RasUnderflow = underflow_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Exception;
  logic        Call;
  logic        Return;
  logic        Halt;
  logic        Resume;
  logic [31:0] PCResult;
  logic        PCValid;
  logic        RasEmpty;
  logic        RasUnderflow;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .Exception(Exception), .Call(Call),
    .Return(Return), .Halt(Halt), .Resume(Resume), .PCResult(PCResult),
    .PCValid(PCValid), .RasEmpty(RasEmpty), .RasUnderflow(RasUnderflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: RAS is a bounded queue (oldest dropped on overflow).
  bit          model_ok = 0;
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_pend;
  logic [31:0] m_pend_t;
  bit          m_uf;
  logic [31:0] m_ras[$];

  task automatic model_step();
    logic [31:0] popped;
    bit          got;
    popped = '0;
    got    = 0;
    if (Reset) begin
      m_pc = 32'h0; m_halted = 0; m_pend = 0; m_uf = 0;
      m_ras.delete();
      model_ok = 1;
      return;
    end
    m_uf = 0;
    if (Exception) begin
      m_halted = 0; m_pc = 32'h180; m_pend = 0;
    end else if (m_halted || Halt || Stall) begin
      if (Redirect) begin m_pend = 1; m_pend_t = RedirectTarget; end
      if (m_halted) begin
        if (Resume) m_halted = 0;
      end else if (Halt) begin
        m_halted = 1;
      end
    end else begin
      if (Return) begin
        if (m_ras.size() > 0) begin popped = m_ras.pop_back(); got = 1; end
        else m_uf = 1;
      end
      if (Call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      if (Redirect)    m_pc = RedirectTarget;
      else if (m_pend) m_pc = m_pend_t;
      else if (got)    m_pc = popped;
      else             m_pc = m_pc + 32'd4;
      m_pend = 0;
    end
  endtask

  always @(posedge Clk) model_step();

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (model_ok) begin
      check("model_pc", PCResult, m_pc);
      check("model_valid", {31'b0, PCValid}, {31'b0, !m_halted});
      check("model_empty", {31'b0, RasEmpty}, {31'b0, (m_ras.size() == 0)});
      check("model_uf", {31'b0, RasUnderflow}, {31'b0, m_uf});
    end
  end

  task automatic idle();
    Reset = 0; Stall = 0; Redirect = 0; RedirectTarget = '0; Exception = 0;
    Call = 0; Return = 0; Halt = 0; Resume = 0;
  endtask

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic go(input logic [31:0] tgt);
    idle(); Redirect = 1; RedirectTarget = tgt; clk1(); idle();
  endtask

  initial begin
    idle();
    Reset = 1;
    clk1();
    $display("reset: pc=%0h valid=%0b empty=%0b", PCResult, PCValid, RasEmpty);
    check("rst_pc", PCResult, 32'h0);
    check("rst_valid", {31'b0, PCValid}, 32'd1);
    check("rst_empty", {31'b0, RasEmpty}, 32'd1);
    check("rst_uf", {31'b0, RasUnderflow}, 32'd0);
    idle();
    for (int i = 1; i <= 3; i++) begin
      clk1();
      check("seq_pc", PCResult, 32'(4 * i));
    end

    // Stall with redirect, held, then released.
    $display("txn: stalled redirect");
    go(32'h10);
    Stall = 1; Redirect = 1; RedirectTarget = 32'h200; clk1();
    check("stall_hold0", PCResult, 32'h10);
    Redirect = 0; clk1();
    check("stall_hold1", PCResult, 32'h10);
    clk1();
    check("stall_hold2", PCResult, 32'h10);
    Stall = 0; clk1();
    check("stall_pend", PCResult, 32'h200);

    // Call/return with underflow.
    $display("txn: call/return/underflow");
    go(32'h40);
    Call = 1; Redirect = 1; RedirectTarget = 32'h100; clk1(); idle();
    Call = 1; clk1(); idle();
    Return = 1; clk1();
    check("ret1", PCResult, 32'h104);
    clk1();
    check("ret2", PCResult, 32'h44);
    check("ret2_empty", {31'b0, RasEmpty}, 32'd1);
    clk1();
    check("ret3_pc", PCResult, 32'h48);
    check("ret3_uf", {31'b0, RasUnderflow}, 32'd1);
    idle(); clk1();
    check("uf_clear", {31'b0, RasUnderflow}, 32'd0);

    // RAS overflow drops oldest.
    $display("txn: ras overflow");
    go(32'h0);
    for (int k = 0; k < 5; k++) begin
      Call = 1; Redirect = 1; RedirectTarget = 32'((k + 1) * 16); clk1();
    end
    idle(); Return = 1;
    for (int k = 0; k < 4; k++) begin
      clk1();
      check("ovf_ret", PCResult, 32'(32'h44 - 16 * k));
    end
    check("ovf_empty", {31'b0, RasEmpty}, 32'd1);
    idle();

    // Exception beats stall and pending redirect.
    $display("txn: exception during stall");
    go(32'h60);
    Stall = 1; Redirect = 1; RedirectTarget = 32'h500; clk1();
    Redirect = 0; Exception = 1; clk1();
    check("exc_pc", PCResult, 32'h180);
    idle(); clk1();
    check("exc_next", PCResult, 32'h184);

    // Wrap-around.
    $display("txn: wrap");
    go(32'hFFFF_FFFC);
    clk1();
    check("wrap", PCResult, 32'h0);

    // Halt, redirect while halted, resume.
    $display("txn: halt/resume");
    go(32'h20);
    Halt = 1; clk1(); idle();
    check("halt_pc", PCResult, 32'h20);
    check("halt_valid", {31'b0, PCValid}, 32'd0);
    Redirect = 1; RedirectTarget = 32'h300; clk1(); idle();
    check("halt_red_pc", PCResult, 32'h20);
    Resume = 1; Halt = 1; clk1(); idle();
    check("resume_pc", PCResult, 32'h20);
    check("resume_valid", {31'b0, PCValid}, 32'd1);
    clk1();
    check("resume_pend", PCResult, 32'h300);

    // Reset while halted with a pending redirect.
    $display("txn: reset mid-halt");
    Halt = 1; Redirect = 1; RedirectTarget = 32'h700; clk1(); idle();
    Reset = 1; clk1(); idle();
    check("rst2_pc", PCResult, 32'h0);
    check("rst2_valid", {31'b0, PCValid}, 32'd1);
    clk1();
    check("rst2_nopend", PCResult, 32'h4);

    // Randomized traffic checked by the model each cycle.
    $display("txn: random phase");
    for (int n = 0; n < 4000; n++) begin
      Reset          = ($urandom_range(0, 299) == 0);
      Stall          = ($urandom_range(0, 3) == 0);
      Redirect       = ($urandom_range(0, 5) == 0);
      RedirectTarget = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                                  : {$urandom_range(0, 16'hFFFF), 2'b00};
      Exception      = ($urandom_range(0, 29) == 0);
      Call           = ($urandom_range(0, 4) == 0);
      Return         = ($urandom_range(0, 4) == 0);
      Halt           = ($urandom_range(0, 19) == 0);
      Resume         = ($urandom_range(0, 3) == 0);
      clk1();
    end
    idle();
    clk1();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
